// File: rtl/mux_write_arbiter.sv
// -----------------------------------------------------------------------------
// mux_write_arbiter
//
// Shares the single write port of the double-buffered `mux` register bank
// between num_req frame producers. A grant covers one whole frame of num_reg
// words written to addresses 0..num_reg-1 in order, followed by one
// write_done pulse that commits the shadow bank. Frames never interleave and
// requesters are served round-robin.
//
// Build option: define MUX_ARB_TIMEOUT_EN to enable the stall timeout. Without
// it, a stalled grant is held indefinitely and frame_abort is tied to 0.
//
// Parameters
//   width    data word width (matches mux)
//   num_reg  words per frame (matches mux)
//   num_req  number of requesters, 2..8
//   timeout  stall limit in cycles (timeout build only)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   req_valid    per-requester word valid
//   req_data     packed words, requester i at [i*width +: width]
//   req_ready    per-requester accept (combinational from grant state)
//   frame_done   per-requester pulse, coincident with write_done
//   frame_abort  per-requester pulse on timeout abort
//   write_addr   mux write address
//   write_data   mux write data
//   write_enable mux write strobe, one cycle per accepted word
//   write_done   mux shadow-bank commit strobe
// -----------------------------------------------------------------------------
module mux_write_arbiter #(
  parameter int width   = 5,
  parameter int num_reg = 3,
  parameter int num_req = 2,
  parameter int timeout = 16,
  localparam int addr_width = (num_reg > 1) ? $clog2(num_reg) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [num_req-1:0]       req_valid,
  input  logic [num_req*width-1:0] req_data,
  output logic [num_req-1:0]       req_ready,
  output logic [num_req-1:0]       frame_done,
  output logic [num_req-1:0]       frame_abort,
  output logic [addr_width-1:0]    write_addr,
  output logic [width-1:0]         write_data,
  output logic                     write_enable,
  output logic                     write_done
);

  localparam int GW = $clog2(num_req);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [addr_width-1:0] LAST_CNT = addr_width'(num_reg - 1);
  localparam logic [GW-1:0]         LAST_RST = GW'(num_req - 1);

  // Elaboration-time guard on the configuration range.
  if (num_req < 2 || num_req > 8 || timeout < 1) begin : g_cfg_check
    $error("mux_write_arbiter: num_req must be 2..8 and timeout >= 1");
  end

  logic [1:0]            r_state;
  logic [GW-1:0]         r_g;
  logic [GW-1:0]         r_last;
  logic [addr_width-1:0] r_cnt;
  logic [addr_width-1:0] r_addr;
  logic [width-1:0]      r_data;
  logic                  r_we;
  logic                  r_done;
  logic [num_req-1:0]    r_frame_done;

  logic [width-1:0]      w_slice [num_req];
  logic [num_req-1:0]    w_ready;
  logic [GW-1:0]         w_pick;
  logic [GW-1:0]         w_idx;
  logic                  w_found;
  logic                  w_xfer;

  for (genvar i = 0; i < num_req; i++) begin : g_slice
    assign w_slice[i] = req_data[i*width +: width];
  end

  // Round-robin search: first valid requester starting just after the last
  // one served, wrapping modulo num_req. The last-served requester is
  // checked last, so it only wins again when nobody else is asking.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= num_req; k++) begin
      w_idx = GW'((int'(r_last) + k) % num_req);
      if (!w_found && req_valid[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_GRANT) w_ready[r_g] = 1'b1;
  end

  assign w_xfer = (r_state == S_GRANT) && req_valid[r_g];

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int SW = $clog2(timeout + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(timeout - 1);

  logic [SW-1:0]      r_stall;
  logic [num_req-1:0] r_frame_abort;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_g          <= '0;
      r_last       <= LAST_RST;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_frame_done <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      r_stall       <= '0;
      r_frame_abort <= '0;
`endif
    end else begin
      // Strobes are single-cycle; address/data hold between writes.
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_frame_done <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      r_frame_abort <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
          r_stall <= '0;
`endif
          if (w_found) begin
            r_g     <= w_pick;
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (w_xfer) begin
            r_we   <= 1'b1;
            r_addr <= r_cnt;
            r_data <= w_slice[r_g];
`ifdef MUX_ARB_TIMEOUT_EN
            r_stall <= '0;
`endif
            if (r_cnt == LAST_CNT) r_state <= S_DONE;
            else                   r_cnt   <= r_cnt + 1'b1;
          end
`ifdef MUX_ARB_TIMEOUT_EN
          // The abort fires on the timeout-th consecutive stalled edge.
          else if (r_stall == STALL_LAST) begin
            r_frame_abort[r_g] <= 1'b1;
            r_last             <= r_g;
            r_state            <= S_IDLE;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
`endif
        end

        S_DONE: begin
          r_done            <= 1'b1;
          r_frame_done[r_g] <= 1'b1;
          r_last            <= r_g;
          r_state           <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = w_ready;
  assign frame_done   = r_frame_done;
  assign write_addr   = r_addr;
  assign write_data   = r_data;
  assign write_enable = r_we;
  assign write_done   = r_done;

`ifdef MUX_ARB_TIMEOUT_EN
  assign frame_abort = r_frame_abort;
`else
  assign frame_abort = '0;
`endif

endmodule

// File: tb/tb_mux_write_arbiter.sv
module tb_mux_write_arbiter;

  localparam int W    = 5;
  localparam int NREG = 3;
  localparam int NREQ = 2;
  localparam int AW   = 2;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   frame_done;
  logic [NREQ-1:0]   frame_abort;
  logic [AW-1:0]     write_addr;
  logic [W-1:0]      write_data;
  logic              write_enable;
  logic              write_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Producer word queues and remaining frame counts for the random phase.
  logic [W-1:0] pq [NREQ][$];
  int           frames_left [NREQ];

  always #5 clk = ~clk;

  mux_write_arbiter #(
    .width   (W),
    .num_reg (NREG),
    .num_req (NREQ),
    .timeout (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_done   (write_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Only requester r asserts valid (r < 0: nobody).
  task automatic set_req(input int r, input logic [W-1:0] d);
    req_valid = '0;
    if (r >= 0) begin
      req_valid[r]       = 1'b1;
      req_data[r*W +: W] = d;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"},   write_enable, 0);
    check({tag, ".wd"},   write_done,   0);
    check({tag, ".addr"}, write_addr,   0);
    check({tag, ".data"}, write_data,   0);
    check({tag, ".fd"},   frame_done,   0);
    check({tag, ".fa"},   frame_abort,  0);
    check({tag, ".rdy"},  req_ready,    0);
  endtask

  // One complete frame from requester r with back-to-back words, an optional
  // stall after word 0, and an optional next requester raising valid in the
  // DONE cycle.
  task automatic run_frame(input int r, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input int stall, input int nxt,
                           input bit granted);
    logic [W-1:0] w [NREG];
    w[0] = w0; w[1] = w1; w[2] = w2;
    if (!granted) begin
      set_req(r, w[0]);
      tick();
      check("grant.rdy", req_ready, 1 << r);
      check("grant.we", write_enable, 0);
    end
    for (int k = 0; k < NREG; k++) begin
      set_req(r, w[k]);
      tick();
      check("xfer.we", write_enable, 1);
      check("xfer.addr", write_addr, k);
      check("xfer.data", write_data, w[k]);
      check("xfer.wd", write_done, 0);
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          set_req(-1, '0);
          tick();
          check("stall.rdy", req_ready, 1 << r);
          check("stall.we", write_enable, 0);
        end
      end
    end
    check("done.rdy", req_ready, 0);
    if (nxt >= 0) set_req(nxt, 5'h0C);
    else          set_req(-1, '0);
    tick();
    check("done.wd", write_done, 1);
    check("done.fd", frame_done, 1 << r);
    check("done.we", write_enable, 0);
    check("done.rdy", req_ready, 0);
    tick();
    check("post.wd", write_done, 0);
    check("post.fd", frame_done, 0);
    check("post.rdy", req_ready, (nxt >= 0) ? (1 << nxt) : 0);
  endtask

  // Reference arbitration: next requester with frames left after `from`.
  function automatic int next_grant(input int from);
    for (int k = 1; k <= NREQ; k++) begin
      if (frames_left[(from + k) % NREQ] > 0) return (from + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic random_phase();
    int total = 0, done = 0, cur, widx = 0, gap = 100, cyc = 0;
    int consec [NREQ];
    bit done_pend = 1'b0;
    bit stall;
    logic [NREQ-1:0] xf;
    logic [W-1:0] word;
    for (int i = 0; i < NREQ; i++) begin
      consec[i]      = 0;
      frames_left[i] = int'($urandom_range(2, 4));
      total         += frames_left[i];
      for (int n = 0; n < frames_left[i] * NREG; n++) pq[i].push_back(W'($urandom));
    end
    rst = 1'b1;
    set_req(-1, '0);
    tick();
    tick();
    rst = 1'b0;
    cur = next_grant(NREQ - 1);
    while (done < total && cyc < 2000) begin
      for (int i = 0; i < NREQ; i++) begin
        stall = (req_ready[i] == 1'b1) && (consec[i] < 2) && ($urandom_range(0, 3) == 0);
        if (pq[i].size() > 0 && !stall) begin
          req_valid[i]       = 1'b1;
          req_data[i*W +: W] = pq[i][0];
          consec[i]          = 0;
        end else begin
          req_valid[i] = 1'b0;
          if (stall) consec[i]++;
        end
      end
      #1;
      xf = req_valid & req_ready;
      tick();
      cyc++;
      gap++;
      word = '0;
      for (int i = 0; i < NREQ; i++) if (xf[i]) word = pq[i].pop_front();
      check("rnd.we", write_enable, |xf);
      check("rnd.fa", frame_abort, 0);
      if (|xf) begin
        check("rnd.owner", xf, 1 << cur);
        check("rnd.addr", write_addr, widx);
        check("rnd.data", write_data, word);
        check("rnd.gap", gap >= 2, 1);
        widx++;
      end
      check("rnd.wd", write_done, done_pend);
      check("rnd.fd", frame_done, done_pend ? (1 << cur) : 0);
      if (done_pend) begin
        frames_left[cur]--;
        done++;
        gap       = 0;
        done_pend = 1'b0;
        cur       = next_grant(cur);
      end
      if (widx == NREG) begin
        done_pend = 1'b1;
        widx      = 0;
      end
      if (done < total) check("rnd.rdy", req_ready & ~(NREQ'(1) << cur), 0);
    end
    check("rnd.frames", done, total);
    set_req(-1, '0);
  endtask

  initial begin
    rst      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;

    // Single frame from requester 0.
    run_frame(0, 5'h11, 5'h05, 5'h1A, 0, -1, 1'b0);

    // Simultaneous request after serving 0: requester 1 wins, then stalls.
    req_valid = 2'b11;
    req_data  = {5'h02, 5'h01};
    tick();
    check("rr.rdy", req_ready, 2'b10);
    run_frame(1, 5'h02, 5'h03, 5'h04, 5, -1, 1'b1);

    // Late arrival of requester 1 during requester 0's DONE cycle.
    run_frame(0, 5'h08, 5'h09, 5'h0A, 0, 1, 1'b0);
    run_frame(1, 5'h10, 5'h12, 5'h13, 0, -1, 1'b1);

    // Reset in the middle of a frame.
    set_req(0, 5'h03);
    tick();
    check("mid.rdy", req_ready, 2'b01);
    tick();
    check("mid.w0", write_addr, 0);
    set_req(0, 5'h04);
    tick();
    check("mid.w1", write_addr, 1);
    rst = 1'b1;
    tick();
    check_zero("mid.rst1");
    tick();
    check_zero("mid.rst2");
    rst = 1'b0;
    set_req(-1, '0);
    tick();
    check_zero("mid.after");
    run_frame(0, 5'h07, 5'h16, 5'h19, 0, -1, 1'b0);

`ifdef MUX_ARB_TIMEOUT_EN
    // Requester 0 stalls after word 1 while requester 1 waits.
    set_req(0, 5'h15);
    tick();
    check("to.rdy", req_ready, 2'b01);
    tick();
    check("to.w0", write_enable, 1);
    set_req(0, 5'h16);
    tick();
    check("to.w1", write_addr, 1);
    req_valid = 2'b10;
    req_data[W +: W] = 5'h1F;
    for (int s = 1; s <= TO; s++) begin
      tick();
      check("to.we", write_enable, 0);
      check("to.wd", write_done, 0);
      check("to.fa", frame_abort, (s == TO) ? 2'b01 : 2'b00);
      check("to.rdy", req_ready, (s == TO) ? 2'b00 : 2'b01);
    end
    tick();
    check("to.next.fa", frame_abort, 0);
    check("to.next.rdy", req_ready, 2'b10);
    run_frame(1, 5'h1F, 5'h1E, 5'h1D, 0, -1, 1'b1);
`endif

    random_phase();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
